react_sched: RTL and testbench
==============================

REACT_SCHED -- requirements
Module: react_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one reactive core (2..8).
REQ-002 Parameter QUANTUM, default 4, maximum consecutive RUN cycles per grant when another requester waits (>=1).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester request level; bit i high = requester i wants core steps.
REQ-006 in_bit  input  NREQ  per-requester input bit forwarded to the core while granted.
REQ-007 core_out  input  1  output bit of the shared reactive core (its __out0).
REQ-008 core_in  output  1  drives the shared core's __in0.
REQ-009 core_rst  output  1  one-cycle pulse restarting the core's resumption state at each context switch.
REQ-010 grant  output  NREQ  one-hot current owner; all zero when idle.
REQ-011 out_valid  output  1  registered strobe: out_bit/out_id carry one core step result.
REQ-012 out_bit  output  1  core_out sampled during a counted RUN cycle.
REQ-013 out_id  output  clog2(NREQ)  index of the requester that owns out_bit.

Function
REQ-014 States IDLE, SWITCH, RUN; one state register, registered id, round-robin pointer ptr, quantum counter cnt of width clog2(QUANTUM+1).
REQ-015 Winner selection: lowest index i at or after ptr (mod NREQ) with req[i]=1; evaluated on current-cycle req.
REQ-016 IDLE: grant=0, core_in=0, core_rst=0; if any req, latch winner into id and go SWITCH; else stay.
REQ-017 SWITCH: lasts exactly one cycle; grant=onehot(id), core_rst=1, core_in=0; next state RUN, cnt<=0.
REQ-018 RUN counted cycle (req[id]=1): grant=onehot(id), core_in=in_bit[id], core_rst=0; next cycle out_valid=1, out_bit=core_out sampled this cycle, out_id=id.
REQ-019 RUN with req[id]=0 (release): cycle not counted, core_in=0, no out_valid; ptr<=id+1 mod NREQ; go SWITCH with new winner (search from id+1) if any other req, else IDLE.
REQ-020 RUN quantum expiry: counted cycle with cnt=QUANTUM-1 and any req[j]=1, j!=id: ptr<=id+1 mod NREQ, go SWITCH with winner searched from id+1.
REQ-021 Quantum expiry with no other requester: stay RUN, cnt<=0, no core_rst pulse.
REQ-022 Otherwise in RUN cnt<=cnt+1.
REQ-023 Simultaneous release and quantum expiry: treated as release (REQ-019).
REQ-024 ptr wraps NREQ-1 -> 0; grant never has more than one bit set.
REQ-025 out_valid is 0 in every cycle not immediately following a counted RUN cycle.

Reset
REQ-026 On rst assertion, immediately: state=IDLE, id=0, ptr=0, cnt=0, grant=0, core_in=0, core_rst=0, out_valid=0, out_bit=0, out_id=0.
REQ-027 Reset mid-RUN discards the session; no out_valid for the in-flight step; first post-reset winner is searched from index 0.

Structure
REQ-028 Package react_sched_pkg holds the state enum type and default NREQ/QUANTUM constants.
REQ-029 Sub-module rr_pick (combinational round-robin picker: req, start pointer -> found flag, index) is instantiated once.

Verification
REQ-030 Single requester: req=4'b0001, in_bit[0]=0 for 6 cycles -> SWITCH with core_rst=1 once, then out_valid on 6 consecutive cycles, out_id=0, out_bit alternating 0,1,0,1,0,1 from toggling core.
REQ-031 Contention: req=4'b0101 held -> grant sequence 0001 (1 SWITCH + 4 RUN), 0100 (1+4), 0001 ..., core_rst pulse at each change, exactly 4 out_valid per slot.
REQ-032 Release: req0 drops after 2 counted cycles with req2 pending -> next cycle SWITCH to id 2, only 2 out_valid with out_id=0.
REQ-033 Wrap: ptr=3, req=4'b1001 -> requester 3 granted first, then 0.
REQ-034 Quantum expiry, lone requester: req=4'b0010 for 10 cycles -> no second core_rst, 10 out_valid.
REQ-035 Reset mid-RUN (cnt=2, id=2): all outputs zero same cycle, IDLE; after release with req=4'b0110, requester 1 granted first.

Source files
------------

// File: rtl/react_sched_pkg.sv
// Shared types and default sizing for the reactive-core scheduler.
package react_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int QUANTUM_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/react_sched_rr_pick.sv
// Combinational round-robin picker: lowest-distance requester at or after start.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Walk farthest-to-nearest so the nearest hit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(start) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/react_sched.sv
// Time-slices one reactive core among NREQ requesters with a round-robin quantum.
module react_sched
    import react_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int QUANTUM = QUANTUM_DEF,
    parameter int IW      = $clog2(NREQ),
    parameter int CW      = $clog2(QUANTUM + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in_bit,
    input  logic            core_out,
    output logic            core_in,
    output logic            core_rst,
    output logic [NREQ-1:0] grant,
    output logic            out_valid,
    output logic            out_bit,
    output logic [IW-1:0]   out_id
);

    state_e          state_r, state_n;
    logic [IW-1:0]   id_r, id_n;
    logic [IW-1:0]   ptr_r, ptr_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [IW-1:0]   id_inc_s;
    logic [IW-1:0]   pick_start_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_found_s;
    logic [NREQ-1:0] owner_s;
    logic            other_req_s;
    logic            step_s;
    logic [NREQ-1:0] grant_s;
    logic            core_in_s;
    logic            core_rst_s;

    assign id_inc_s     = (id_r == IW'(NREQ - 1)) ? '0 : id_r + IW'(1);
    assign owner_s      = {{(NREQ-1){1'b0}}, 1'b1} << id_r;
    assign other_req_s  = |(req & ~owner_s);
    // While running, the search starts past the owner so it is considered last.
    assign pick_start_s = (state_r == ST_RUN) ? id_inc_s : ptr_r;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state and core-facing controls.
    always_comb begin
        state_n    = state_r;
        id_n       = id_r;
        ptr_n      = ptr_r;
        cnt_n      = cnt_r;
        grant_s    = '0;
        core_in_s  = 1'b0;
        core_rst_s = 1'b0;
        step_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    id_n    = pick_idx_s;
                    state_n = ST_SWITCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SWITCH: begin
                grant_s    = owner_s;
                core_rst_s = 1'b1;
                cnt_n      = '0;
                state_n    = ST_RUN;
            end
            ST_RUN: begin
                grant_s = owner_s;
                if (!req[id_r]) begin
                    ptr_n = id_inc_s;
                    if (pick_found_s) begin
                        id_n    = pick_idx_s;
                        state_n = ST_SWITCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    core_in_s = in_bit[id_r];
                    step_s    = 1'b1;
                    if (cnt_r == CW'(QUANTUM - 1)) begin
                        if (other_req_s) begin
                            ptr_n   = id_inc_s;
                            id_n    = pick_idx_s;
                            state_n = ST_SWITCH;
                        end else begin
                            cnt_n = '0;
                        end
                    end else begin
                        cnt_n = cnt_r + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            id_r    <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            id_r    <= id_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
        end
    end

    // Capture of each counted core step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_id    <= '0;
        end else begin
            out_valid <= step_s;
            if (step_s) begin
                out_bit <= core_out;
                out_id  <= id_r;
            end
        end
    end

    assign grant    = grant_s;
    assign core_in  = core_in_s;
    assign core_rst = core_rst_s;

endmodule

// File: tb/tb_react_sched.sv
// Directed vector bench for react_sched with a toggling stand-in core.
module tb_react_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] in_bit = 4'b0000;
    logic       core_out;
    logic       core_in;
    logic       core_rst;
    logic [3:0] grant;
    logic       out_valid;
    logic       out_bit;
    logic [1:0] out_id;
    logic       tq;

    int n_chk  = 0;
    int n_fail = 0;

    react_sched #(.NREQ(4), .QUANTUM(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_bit    (in_bit),
        .core_out  (core_out),
        .core_in   (core_in),
        .core_rst  (core_rst),
        .grant     (grant),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // Stand-in core: toggles each stepped cycle, restarts on core_rst, output XORed with input.
    always @(posedge clk or posedge rst) begin
        if (rst)          tq <= 1'b0;
        else if (core_rst) tq <= 1'b0;
        else if (|grant)  tq <= ~tq;
    end
    assign core_out = tq ^ core_in;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] inb;
        logic [3:0] grant;
        logic       crst;
        logic       cin;
        logic       vld;
        logic       obit;
        logic [1:0] oid;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ib,
                       input logic [3:0] g, input logic cr, input logic ci,
                       input logic v, input logic b, input logic [1:0] id);
        vec_t e;
        e.rst = r; e.req = rq; e.inb = ib; e.grant = g; e.crst = cr;
        e.cin = ci; e.vld = v; e.obit = b; e.oid = id;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        in_bit = 4'b0000;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int crst_cnt;
        int vld_cnt;

        // Single requester, lone-requester quantum rollover, release to idle.
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        // Contention 0101 with in_bit high: quantum hand-offs 0 -> 2 -> 0.
        add(1, 4'b0101, 4'b0101, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 1, 0, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 1, 1, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 1, 1, 0);
        add(0, 4'b0101, 4'b0101, 4'b0100, 1, 0, 1, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0100, 0, 1, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0100, 0, 1, 1, 1, 2);
        add(0, 4'b0101, 4'b0101, 4'b0100, 0, 1, 1, 0, 2);
        add(0, 4'b0101, 4'b0101, 4'b0100, 0, 1, 1, 1, 2);
        add(0, 4'b0101, 4'b0101, 4'b0001, 1, 0, 1, 0, 2);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 0, 0, 0);
        add(0, 4'b0101, 4'b0101, 4'b0001, 0, 1, 1, 1, 0);
        // Requester 0 releases after two counted steps; 2 pending takes over.
        add(0, 4'b0100, 4'b0101, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 4'b0101, 4'b0100, 1, 0, 0, 0, 0);
        add(0, 4'b0100, 4'b0101, 4'b0100, 0, 1, 0, 0, 0);
        add(0, 4'b0000, 4'b0101, 4'b0100, 0, 0, 1, 1, 2);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        // Pointer at 3 with 1001: requester 3 first, then wrap to 0.
        add(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 1, 0, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 0, 0, 0, 0, 0);
        add(0, 4'b1001, 4'b0000, 4'b1000, 0, 0, 1, 0, 3);
        add(0, 4'b1001, 4'b0000, 4'b1000, 0, 0, 1, 1, 3);
        add(0, 4'b1001, 4'b0000, 4'b1000, 0, 0, 1, 0, 3);
        add(0, 4'b1001, 4'b0000, 4'b0001, 1, 0, 1, 1, 3);
        add(0, 4'b1001, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);

        // Reset state, checked while rst is held.
        #2;
        chk("reset grant", grant, 4'b0000);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset core_rst", core_rst, 1'b0);
        do_reset();

        foreach (tbl[i]) begin
            rst    = tbl[i].rst;
            req    = tbl[i].req;
            in_bit = tbl[i].inb;
            @(negedge clk);
            chk($sformatf("v%0d grant", i), grant, tbl[i].grant);
            chk($sformatf("v%0d core_rst", i), core_rst, tbl[i].crst);
            chk($sformatf("v%0d core_in", i), core_in, tbl[i].cin);
            chk($sformatf("v%0d out_valid", i), out_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d out_bit", i), out_bit, tbl[i].obit);
                chk($sformatf("v%0d out_id", i), out_id, tbl[i].oid);
            end
            next_cycle();
        end

        // Lone requester 1 for ten steps: one restart only, ten results.
        do_reset();
        crst_cnt = 0;
        vld_cnt  = 0;
        for (int c = 0; c < 14; c++) begin
            req = (c < 12) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            if (core_rst) crst_cnt++;
            if (out_valid) begin
                chk($sformatf("lone c%0d out_id", c), out_id, 2'd1);
                chk($sformatf("lone c%0d out_bit", c), out_bit, vld_cnt[0]);
                vld_cnt++;
            end
            next_cycle();
        end
        chk("lone core_rst count", crst_cnt, 32'd1);
        chk("lone out_valid count", vld_cnt, 32'd10);

        // Asynchronous reset in the middle of a run slot of requester 2.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        chk("midrun grant before", grant, 4'b0100);
        chk("midrun valid before", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun grant", grant, 4'b0000);
        chk("midrun core_in", core_in, 1'b0);
        chk("midrun core_rst", core_rst, 1'b0);
        chk("midrun out_valid", out_valid, 1'b0);
        chk("midrun out_bit", out_bit, 1'b0);
        chk("midrun out_id", out_id, 2'd0);
        next_cycle();
        rst = 1'b0;
        req = 4'b0110;
        @(negedge clk);
        chk("post-reset idle grant", grant, 4'b0000);
        chk("post-reset out_valid", out_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("post-reset first grant", grant, 4'b0010);
        chk("post-reset core_rst", core_rst, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
